// File: rtl/lfsr_pkg.sv
// Shared types and the polynomial table for the lfsr_gen family.
package lfsr_pkg;

    localparam int LFSR_MIN_N = 2;
    localparam int LFSR_MAX_N = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_e;

    typedef enum logic {
        FIBONACCI = 1'b0,
        GALOIS    = 1'b1
    } lfsr_mode_e;

    // Maximal-length feedback mask: bit (e-1) is set for every term x^e.
    function automatic logic [15:0] lfsr_taps(input int n);
        logic [15:0] t;
        case (n)
            2:       t = 16'h0003;  // x^2 + x + 1
            3:       t = 16'h0006;  // x^3 + x^2 + 1
            4:       t = 16'h000C;  // x^4 + x^3 + 1
            5:       t = 16'h0014;  // x^5 + x^3 + 1
            6:       t = 16'h0030;  // x^6 + x^5 + 1
            7:       t = 16'h0060;  // x^7 + x^6 + 1
            8:       t = 16'h00B8;  // x^8 + x^6 + x^5 + x^4 + 1
            9:       t = 16'h0110;  // x^9 + x^5 + 1
            10:      t = 16'h0240;  // x^10 + x^7 + 1
            11:      t = 16'h0500;  // x^11 + x^9 + 1
            12:      t = 16'h0829;  // x^12 + x^6 + x^4 + x + 1
            13:      t = 16'h100D;  // x^13 + x^4 + x^3 + x + 1
            14:      t = 16'h2015;  // x^14 + x^5 + x^3 + x + 1
            15:      t = 16'h6000;  // x^15 + x^14 + 1
            16:      t = 16'hD008;  // x^16 + x^15 + x^13 + x^4 + 1
            default: t = 16'h0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the LFSR, Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] s,
    input  lfsr_mode_e   mode,
    output logic [N-1:0] next
);

    localparam logic [15:0]  TAPS_ALL = lfsr_taps(N);
    localparam logic [N-1:0] TAPS     = TAPS_ALL[N-1:0];

    logic [N-1:0] fib_next;
    logic [N-1:0] gal_next;

    // Fibonacci shifts in the parity of the tapped bits; Galois feeds the
    // outgoing MSB back into every tapped position (and into bit 0).
    assign fib_next[0] = ^(s & TAPS);
    assign gal_next[0] = s[N-1];

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_bit
            assign fib_next[gi] = s[gi-1];
            assign gal_next[gi] = s[gi-1] ^ (s[N-1] & TAPS[gi-1]);
        end
    endgenerate

    assign next = (mode == GALOIS) ? gal_next : fib_next;

endmodule

// File: rtl/lfsr_gen.sv
// Run/stop LFSR source with valid/ready output, period measurement,
// one-shot mode and all-zero seed protection.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_seed,
    input  logic [N-1:0] seed_data,
    input  logic         mode,
    input  logic         start,
    input  logic         stop,
    input  logic         one_shot,
    input  logic         lfsr_ready,
    output logic         lfsr_valid,
    output logic [N-1:0] lfsr_data,
    output logic         lfsr_done,
    output logic [N-1:0] period,
    output logic         zero_seed_err
);

    generate
        if (N < LFSR_MIN_N || N > LFSR_MAX_N) begin : g_bad_n
            $error("lfsr_gen: N=%0d is outside the supported range 2..16", N);
        end
    endgenerate

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    lfsr_state_e  state_reg,  state_next;
    lfsr_mode_e   mode_reg,   mode_next;
    logic [N-1:0] lfsr_reg,   lfsr_next;
    logic [N-1:0] seed_reg,   seed_next;
    logic [N-1:0] cnt_reg,    cnt_next;
    logic [N-1:0] period_reg, period_next;
    logic         done_reg,   done_next;
    logic         zerr_reg,   zerr_next;

    logic [N-1:0] step_value;
    logic         step_en;

    lfsr_step #(.N(N)) u_step (
        .s    (lfsr_reg),
        .mode (mode_reg),
        .next (step_value)
    );

    // A step happens only on a transfer that is not overridden by load or stop.
    assign step_en = (state_reg == RUN) && lfsr_ready && !stop && !load_seed;

    // Next-state logic; branch order encodes load > stop > step > start.
    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        lfsr_next   = lfsr_reg;
        seed_next   = seed_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        done_next   = 1'b0;
        zerr_next   = zerr_reg;

        if (load_seed) begin
            // An all-zero seed would lock the register, so substitute all-ones.
            if (seed_data == '0) begin
                lfsr_next = '1;
                seed_next = '1;
                zerr_next = 1'b1;
            end else begin
                lfsr_next = seed_data;
                seed_next = seed_data;
            end
            mode_next  = lfsr_mode_e'(mode);
            cnt_next   = '0;
            state_next = IDLE;
        end else if (stop) begin
            state_next = IDLE;
        end else if (step_en) begin
            lfsr_next = step_value;
            if (step_value == seed_reg) begin
                period_next = cnt_reg + ONE;
                cnt_next    = '0;
                done_next   = 1'b1;
                if (one_shot) begin
                    state_next = IDLE;
                end
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end else if (start && state_reg == IDLE) begin
            state_next = RUN;
        end
    end

    // State registers with asynchronous return to reset values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            mode_reg   <= FIBONACCI;
            lfsr_reg   <= '1;
            seed_reg   <= '1;
            cnt_reg    <= '0;
            period_reg <= '0;
            done_reg   <= 1'b0;
            zerr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            lfsr_reg   <= lfsr_next;
            seed_reg   <= seed_next;
            cnt_reg    <= cnt_next;
            period_reg <= period_next;
            done_reg   <= done_next;
            zerr_reg   <= zerr_next;
        end
    end

    assign lfsr_valid    = (state_reg == RUN);
    assign lfsr_data     = lfsr_reg;
    assign lfsr_done     = done_reg;
    assign period        = period_reg;
    assign zero_seed_err = zerr_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a 4-bit and an 8-bit instance share the clock.
module tb_lfsr_gen;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       ld4, mode4, start4, stop4, os4, rdy4;
    logic [3:0] seed4;
    logic       valid4, done4, zerr4;
    logic [3:0] data4, period4;

    logic       ld8, mode8, start8, stop8, os8, rdy8;
    logic [7:0] seed8;
    logic       valid8, done8, zerr8;
    logic [7:0] data8, period8;

    lfsr_gen #(.N(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .load_seed(ld4), .seed_data(seed4),
        .mode(mode4), .start(start4), .stop(stop4), .one_shot(os4),
        .lfsr_ready(rdy4), .lfsr_valid(valid4), .lfsr_data(data4),
        .lfsr_done(done4), .period(period4), .zero_seed_err(zerr4)
    );

    lfsr_gen #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .load_seed(ld8), .seed_data(seed8),
        .mode(mode8), .start(start8), .stop(stop8), .one_shot(os8),
        .lfsr_ready(rdy8), .lfsr_valid(valid8), .lfsr_data(data8),
        .lfsr_done(done8), .period(period8), .zero_seed_err(zerr8)
    );

    typedef struct {
        logic [15:0] data;
        logic        done;
        logic        run;
        logic [15:0] period;
        logic        zerr;
    } exp_t;

    exp_t sb_q[$];

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state, index 0 = 4-bit instance, 1 = 8-bit instance.
    logic [15:0] m_state [2];
    logic [15:0] m_seed  [2];
    logic [15:0] m_period[2];
    logic        m_run   [2];
    logic        m_gal   [2];
    logic        m_zerr  [2];
    int          m_cnt   [2];

    logic [3:0] fib_seq [3] = '{4'h2, 4'h4, 4'h9};
    logic [3:0] gal_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h9};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbits(input int w);
        return (w == 0) ? 4 : 8;
    endfunction

    // x^4+x^3+1 and x^8+x^6+x^5+x^4+1
    function automatic logic [15:0] taps_of(input int w);
        return (w == 0) ? 16'h000C : 16'h00B8;
    endfunction

    function automatic logic [15:0] mask_of(input int w);
        return 16'((32'd1 << nbits(w)) - 32'd1);
    endfunction

    function automatic logic [15:0] model_next(input int w, input logic gal, input logic [15:0] s);
        logic [15:0] r;
        logic [15:0] m;
        int          n;
        n = nbits(w);
        m = mask_of(w);
        if (!gal) begin
            r = ((s << 1) | 16'(^(s & taps_of(w)))) & m;
        end else begin
            r = (s << 1) & m;
            if (s[n-1]) r = r ^ (((taps_of(w) << 1) | 16'd1) & m);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_state[w]  = mask_of(w);
            m_seed[w]   = mask_of(w);
            m_period[w] = '0;
            m_run[w]    = 1'b0;
            m_gal[w]    = 1'b0;
            m_zerr[w]   = 1'b0;
            m_cnt[w]    = 0;
        end
    endtask

    task automatic observe(input int w, output exp_t o);
        o.data   = (w == 0) ? 16'(data4)   : 16'(data8);
        o.done   = (w == 0) ? done4        : done8;
        o.run    = (w == 0) ? valid4       : valid8;
        o.period = (w == 0) ? 16'(period4) : 16'(period8);
        o.zerr   = (w == 0) ? zerr4        : zerr8;
    endtask

    // One clock of stimulus on instance w; the other instance is held quiet.
    task automatic cyc(input int w, input logic ld, input logic [15:0] sd, input logic md,
                       input logic st, input logic sp, input logic os, input logic rdy);
        exp_t        e;
        exp_t        o;
        logic [15:0] nxt;
        logic [15:0] sdm;
        logic        xfer;

        ld4 = 1'b0; start4 = 1'b0; stop4 = 1'b0; os4 = 1'b0; rdy4 = 1'b0;
        ld8 = 1'b0; start8 = 1'b0; stop8 = 1'b0; os8 = 1'b0; rdy8 = 1'b0;
        if (w == 0) begin
            ld4 = ld; seed4 = sd[3:0]; mode4 = md; start4 = st; stop4 = sp; os4 = os; rdy4 = rdy;
        end else begin
            ld8 = ld; seed8 = sd[7:0]; mode8 = md; start8 = st; stop8 = sp; os8 = os; rdy8 = rdy;
        end

        xfer   = 1'b0;
        e.done = 1'b0;
        sdm    = sd & mask_of(w);
        if (ld) begin
            if (sdm == '0) begin
                m_state[w] = mask_of(w);
                m_seed[w]  = mask_of(w);
                m_zerr[w]  = 1'b1;
            end else begin
                m_state[w] = sdm;
                m_seed[w]  = sdm;
            end
            m_gal[w] = md;
            m_cnt[w] = 0;
            m_run[w] = 1'b0;
        end else if (sp) begin
            m_run[w] = 1'b0;
        end else if (m_run[w] && rdy) begin
            xfer       = 1'b1;
            nxt        = model_next(w, m_gal[w], m_state[w]);
            m_state[w] = nxt;
            m_cnt[w]++;
            if (nxt == m_seed[w]) begin
                m_period[w] = 16'(m_cnt[w]);
                m_cnt[w]    = 0;
                e.done      = 1'b1;
                if (os) m_run[w] = 1'b0;
            end
        end else if (st) begin
            m_run[w] = 1'b1;
        end
        e.data   = m_state[w];
        e.run    = m_run[w];
        e.period = m_period[w];
        e.zerr   = m_zerr[w];
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        observe(w, o);
        check($sformatf("dut%0d data", nbits(w)),   o.data,         e.data);
        check($sformatf("dut%0d done", nbits(w)),   16'(o.done),    16'(e.done));
        check($sformatf("dut%0d valid", nbits(w)),  16'(o.run),     16'(e.run));
        check($sformatf("dut%0d period", nbits(w)), o.period,       e.period);
        check($sformatf("dut%0d zerr", nbits(w)),   16'(o.zerr),    16'(e.zerr));
        if (xfer)
            $display("xfer dut%0d data=0x%0h done=%0d period=%0d",
                     nbits(w), o.data, o.done, o.period);
    endtask

    initial begin
        int          xfers;
        logic [15:0] rseed;

        reset_n = 1'b0;
        ld4 = 0; mode4 = 0; start4 = 0; stop4 = 0; os4 = 0; rdy4 = 0; seed4 = '0;
        ld8 = 0; mode8 = 0; start8 = 0; stop8 = 0; os8 = 0; rdy8 = 0; seed8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst data8",   16'(data8),   16'h00FF);
        check("rst valid8",  16'(valid8),  16'h0);
        check("rst period8", 16'(period8), 16'h0);
        check("rst done8",   16'(done8),   16'h0);
        check("rst zerr8",   16'(zerr8),   16'h0);
        check("rst data4",   16'(data4),   16'h000F);
        reset_n = 1'b1;

        // 4-bit Fibonacci from seed 0001
        cyc(0, 1, 16'h1, 0, 0, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 1, 0, 0, 1);
        check("fib4 valid after start", 16'(valid4), 16'h1);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);
            if (k <= 3) check($sformatf("fib4 step%0d", k), 16'(data4), 16'(fib_seq[k-1]));
        end
        check("fib4 done", 16'(done4), 16'h1);
        check("fib4 period", 16'(period4), 16'd15);
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 1, 0, 1);

        // 4-bit Galois from seed 0001
        cyc(0, 1, 16'h1, 1, 0, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);
            if (k <= 4) check($sformatf("gal4 step%0d", k), 16'(data4), 16'(gal_seq[k-1]));
        end
        check("gal4 done", 16'(done4), 16'h1);
        check("gal4 period", 16'(period4), 16'd15);

        // Backpressure: ready 1,0,0,1
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(0, 0, 16'h0, 0, 0, 1, 0, 1);

        // Zero seed protection, then load together with start
        cyc(0, 1, 16'h0, 0, 0, 0, 0, 0);
        check("zero seed err", 16'(zerr4), 16'h1);
        check("zero seed data", 16'(data4), 16'h000F);
        cyc(0, 1, 16'h5, 0, 1, 0, 0, 1);
        check("load+start idle", 16'(valid4), 16'h0);
        cyc(0, 0, 16'h0, 0, 0, 0, 0, 1);

        // 8-bit one-shot over a full period from a random seed
        rseed = 16'($urandom_range(1, 255));
        cyc(1, 1, rseed, 0, 0, 0, 0, 0);
        cyc(1, 0, 16'h0, 0, 1, 0, 1, 1);
        xfers = 0;
        for (int k = 0; k < 300 && m_run[1]; k++) begin
            if (valid8) xfers++;
            cyc(1, 0, 16'h0, 0, 0, 0, 1, 1);
        end
        check("oneshot finished", 16'(m_run[1]), 16'h0);
        check("oneshot transfers", 16'(xfers), 16'd255);
        check("oneshot done", 16'(done8), 16'h1);
        check("oneshot valid low", 16'(valid8), 16'h0);
        check("oneshot period", 16'(period8), 16'd255);
        cyc(1, 0, 16'h0, 0, 0, 0, 1, 1);

        // 8-bit Galois, stop mid-run freezes the word, then resume
        rseed = 16'($urandom_range(1, 255));
        cyc(1, 1, rseed, 1, 0, 0, 0, 0);
        cyc(1, 0, 16'h0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 10; k++) cyc(1, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(1, 0, 16'h0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) cyc(1, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(1, 0, 16'h0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 5; k++) cyc(1, 0, 16'h0, 0, 0, 0, 0, 1);

        // Reset asserted mid-run takes effect without a clock edge
        reset_n = 1'b0;
        #1;
        check("midrst data8",   16'(data8),   16'h00FF);
        check("midrst valid8",  16'(valid8),  16'h0);
        check("midrst period8", 16'(period8), 16'h0);
        check("midrst done8",   16'(done8),   16'h0);
        check("midrst zerr4",   16'(zerr4),   16'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1, 0, 16'h0, 0, 0, 0, 0, 1);
        cyc(1, 0, 16'h0, 0, 1, 0, 0, 1);
        cyc(1, 0, 16'h0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
